scanned_screen_driver: RTL

Time-multiplexed display scanner that sits after `screen_driver` and drives a common-anode/cathode multi-digit 7-segment display over one shared segment bus. It accepts a full frame of per-digit segment patterns through a valid/ready handshake, double-buffers it so a frame never tears mid-scan, and adds brightness PWM and per-digit blinking. It is the parametrised successor to the static `screen_driver` output, generalised in digit count, scan rate and output polarity.

---
 rtl/scanned_screen_driver.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/scanned_screen_driver.sv
// -----------------------------------------------------------------------------
// scanned_screen_driver
//
// Drives a multi-digit 7-segment display over one shared segment bus. Digits
// are scanned one at a time, and each digit is selected for ScanDiv cycles.
// A whole frame of segment patterns is accepted through a valid/ready
// handshake into a pending buffer. That buffer is copied into the display
// buffer only at a frame start, so a frame never changes half way through a
// scan. Brightness is a PWM duty within each digit slot. Any digit can be set
// to blink with a half-period of BlinkDiv frames.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   segments_i     frame to show, one byte per digit (bit 7 = dp, 1 = lit)
//   blink_mask_i   per-digit blink enable, captured together with segments_i
//   load_valid_i   a frame is offered
//   load_ready_o   a frame can be accepted (pending buffer empty)
//   brightness_i   duty level: 0 = 1/8 ... 7 = 8/8
//   digit_sel_o    one-hot active digit (polarity set by ActiveLow)
//   segments_o     segments of the active digit (polarity set by ActiveLow)
//   frame_o        one-cycle pulse in the first output cycle of each frame
//
// Pending buffer states:
//   state     | meaning
//   BUF_EMPTY | no frame waiting; load_ready_o high
//   BUF_FULL  | frame waiting for the next frame start; load_ready_o low
// -----------------------------------------------------------------------------
module scanned_screen_driver #(
  parameter int NumDigits = 4,
  parameter int ScanDiv   = 1024,
  parameter int BlinkDiv  = 32,
  parameter bit ActiveLow = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumDigits-1:0][7:0] segments_i,
  input  logic [NumDigits-1:0]      blink_mask_i,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [2:0]                brightness_i,
  output logic [NumDigits-1:0]      digit_sel_o,
  output logic [7:0]                segments_o,
  output logic                      frame_o
);

  localparam int SlotW = $clog2(ScanDiv);
  localparam int DigW  = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam int FrmW  = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(ScanDiv - 1);
  localparam logic [DigW-1:0]  DigLast  = DigW'(NumDigits - 1);
  localparam logic [FrmW-1:0]  FrmLast  = FrmW'(BlinkDiv - 1);
  localparam logic [SlotW:0]   Eighth   = (SlotW + 1)'(ScanDiv / 8);
  localparam logic             Inv      = ActiveLow;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // scan counters
  logic [SlotW-1:0] slot_cnt_q, slot_cnt_d;
  logic [DigW-1:0]  digit_idx_q, digit_idx_d;
  logic [FrmW-1:0]  frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  // frame buffers
  buf_state_e                state_q, state_d;
  logic [NumDigits-1:0][7:0] pend_seg_q, pend_seg_d;
  logic [NumDigits-1:0]      pend_mask_q, pend_mask_d;
  logic [NumDigits-1:0][7:0] disp_seg_q, disp_seg_d;
  logic [NumDigits-1:0]      disp_mask_q, disp_mask_d;
  logic [2:0]                bright_q, bright_d;

  // registered pin outputs
  logic [NumDigits-1:0] digit_sel_q, digit_sel_d;
  logic [7:0]           segments_q, segments_d;
  logic                 frame_q, frame_d;

  logic                 slot_wrap, digit_wrap, frame_wrap;
  logic                 frame_start, accept, swap;
  logic [SlotW:0]       pwm_limit;
  logic                 pwm_on, blanked;
  logic [7:0]           seg_int;
  logic [NumDigits-1:0] sel_int;

  // ---------------------------------------------------------------------------
  // Scan counters: slot -> digit -> frame -> blink phase
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_wrap   = (slot_cnt_q == SlotLast);
    digit_wrap  = (digit_idx_q == DigLast);
    frame_wrap  = (frame_cnt_q == FrmLast);
    frame_start = (slot_cnt_q == '0) && (digit_idx_q == '0);

    slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;

    if (slot_wrap) begin
      digit_idx_d = digit_wrap ? '0 : digit_idx_q + 1'b1;
      if (digit_wrap) begin
        frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
        if (frame_wrap) begin
          blink_phase_d = ~blink_phase_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending buffer handshake and frame-start swap.
  // A frame can be accepted only while the buffer is empty. A swap needs a
  // full buffer. So an accept and a swap in the same cycle cannot act on the
  // same data, and a newly accepted frame waits for the next frame start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pend_seg_d  = pend_seg_q;
    pend_mask_d = pend_mask_q;
    accept      = 1'b0;
    swap        = 1'b0;

    case (state_q)
      BUF_EMPTY: begin
        if (load_valid_i) begin
          accept      = 1'b1;
          pend_seg_d  = segments_i;
          pend_mask_d = blink_mask_i;
          state_d     = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (frame_start) begin
          swap    = 1'b1;
          state_d = BUF_EMPTY;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase

    // The output stage reads the post-swap contents. Digit 0 of a new frame
    // therefore shows the new data from its very first cycle.
    disp_seg_d  = swap ? pend_seg_q  : disp_seg_q;
    disp_mask_d = swap ? pend_mask_q : disp_mask_q;
  end

  assign load_ready_o = (state_q == BUF_EMPTY);

  // ---------------------------------------------------------------------------
  // Output stage: PWM, blink gating and pin polarity
  // ---------------------------------------------------------------------------
  always_comb begin
    bright_d = (slot_cnt_q == '0) ? brightness_i : bright_q;

    // Lit window covers the first (level+1)/8 of the slot.
    pwm_limit = ({{(SlotW - 2){1'b0}}, bright_d} + (SlotW + 1)'(1)) * Eighth;
    pwm_on    = ({1'b0, slot_cnt_q} < pwm_limit);
    blanked   = blink_phase_q && disp_mask_d[digit_idx_q];

    seg_int = (pwm_on && !blanked) ? disp_seg_d[digit_idx_q] : 8'h00;

    sel_int              = '0;
    sel_int[digit_idx_q] = 1'b1;

    digit_sel_d = sel_int ^ {NumDigits{Inv}};
    segments_d  = seg_int ^ {8{Inv}};
    frame_d     = frame_start;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      state_q       <= BUF_EMPTY;
      pend_seg_q    <= '0;
      pend_mask_q   <= '0;
      disp_seg_q    <= '0;
      disp_mask_q   <= '0;
      bright_q      <= '0;
      digit_sel_q   <= {NumDigits{Inv}};
      segments_q    <= {8{Inv}};
      frame_q       <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      state_q       <= state_d;
      pend_seg_q    <= pend_seg_d;
      pend_mask_q   <= pend_mask_d;
      disp_seg_q    <= disp_seg_d;
      disp_mask_q   <= disp_mask_d;
      bright_q      <= bright_d;
      digit_sel_q   <= digit_sel_d;
      segments_q    <= segments_d;
      frame_q       <= frame_d;
    end
  end

  assign digit_sel_o = digit_sel_q;
  assign segments_o  = segments_q;
  assign frame_o     = frame_q;

endmodule
